cdc_2phase_channel: RTL and testbench

- Single-clock, two-phase (toggle) bundled-data transfer channel with valid/ready handshakes on both sides.
- The source side captures a word and toggles a request flag. The request crosses to the destination through a configurable synchronizer chain. The destination toggles an acknowledge flag, which returns through an identical chain.
- Used to decouple timing between producer and consumer partitions.
- Provides the same protocol and latency profile as the team's dual-clock 2-phase CDC, so it can stand in for it in single-clock builds.

---
 rtl/cdc_2phase_channel_pkg.sv | 18 +
 rtl/cdc_2phase_channel_sync.sv | 39 +++
 rtl/cdc_2phase_channel.sv | 81 ++++++++
 tb/tb_cdc_2phase_channel.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cdc_2phase_channel_pkg.sv
// Shared defaults and types for the two-phase toggle handshake channel.
// Optional checker macro: CDC_2PHASE_CHANNEL_PROTOCOL_CHECK_EN (used by the top).
package cdc_2phase_channel_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES     = 4;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

  // Out-of-range depths are pulled back into 1..MAX_SYNC_STAGES.
  function automatic int clamp_sync_stages(input int n);
    if (n < 1) return 1;
    if (n > MAX_SYNC_STAGES) return MAX_SYNC_STAGES;
    return n;
  endfunction

endpackage

// File: rtl/cdc_2phase_channel_sync.sv
// 1-bit flop chain of configurable depth with asynchronous active-high reset to 0.
module cdc_2phase_channel_sync
  import cdc_2phase_channel_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int DEPTH = clamp_sync_stages(STAGES);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic stage_q;
      logic stage_d;

      if (gi == 0) begin : g_first
        assign stage_d = d;
      end else begin : g_rest
        assign stage_d = g_stage[gi-1].stage_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_q <= 1'b0;
        end else begin
          stage_q <= stage_d;
        end
      end
    end
  endgenerate

  assign q = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/cdc_2phase_channel.sv
// Two-phase (toggle) bundled-data channel with valid/ready on both sides.
// Define CDC_2PHASE_CHANNEL_PROTOCOL_CHECK_EN to include protocol assertions.
module cdc_2phase_channel
  import cdc_2phase_channel_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] src_data_i,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  output logic [DATA_WIDTH-1:0] dst_data_o,
  output logic                  dst_valid_o,
  input  logic                  dst_ready_i
);

  logic                  req_q;
  logic                  ack_q;
  logic                  req_synced;
  logic                  ack_synced;
  logic [DATA_WIDTH-1:0] data_q;

  // Only flag equality matters, so the toggles may wrap freely.
  assign src_ready_o = (req_q == ack_synced);
  assign dst_valid_o = (req_synced != ack_q);
  assign dst_data_o  = data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q  <= 1'b0;
      data_q <= '0;
    end else if (src_valid_i && src_ready_o) begin
      req_q  <= ~req_q;
      data_q <= src_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
    end else if (dst_valid_o && dst_ready_i) begin
      ack_q <= ~ack_q;
    end
  end

  cdc_2phase_channel_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (req_q),
    .q   (req_synced)
  );

  cdc_2phase_channel_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (ack_q),
    .q   (ack_synced)
  );

`ifdef CDC_2PHASE_CHANNEL_PROTOCOL_CHECK_EN
  a_src_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (src_valid_i && !src_ready_o) |=> src_valid_i)
    else $error("src_valid_i dropped before handshake");

  a_src_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (src_valid_i && !src_ready_o && $past(src_valid_i && !src_ready_o)) |-> $stable(src_data_i))
    else $error("src_data_i changed while waiting for handshake");

  a_dst_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (dst_valid_o && $past(dst_valid_o && !dst_ready_i)) |-> $stable(dst_data_o))
    else $error("dst_data_o changed while waiting for handshake");

  // Idle source and pending delivery at once would mean a token delivered twice.
  a_no_double_delivery: assert property (@(posedge clk_i) disable iff (rst_i)
    !(src_ready_o && dst_valid_o))
    else $error("src_ready_o and dst_valid_o both high");
`endif

endmodule

// File: tb/tb_cdc_2phase_channel.sv
// Directed bench for cdc_2phase_channel: reset, single transfer, back-to-back,
// backpressure hold and reset mid-flight. Latencies are derived from S.
module tb_cdc_2phase_channel;
  import cdc_2phase_channel_pkg::*;

  parameter int S = DEFAULT_SYNC_STAGES;

  logic  clk_i = 1'b0;
  logic  rst_i;
  word_t src_data_i;
  logic  src_valid_i;
  logic  src_ready_o;
  word_t dst_data_o;
  logic  dst_valid_o;
  logic  dst_ready_i;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cycle        = 0;

  cdc_2phase_channel #(
    .DATA_WIDTH  (DEFAULT_DATA_WIDTH),
    .SYNC_STAGES (S)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .src_data_i  (src_data_i),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .dst_data_o  (dst_data_o),
    .dst_valid_o (dst_valid_o),
    .dst_ready_i (dst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    end else begin
      $display("ok   %s: %h (cycle %0d)", tag, got, cycle);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cycle++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    word_t words [2];
    int    idx, rx, first_rx;
    int    acc [2];
    int    accepts, valid_seen;
    bit    fire_src, fire_dst;
    word_t rx_word;

    rst_i       = 1'b1;
    src_data_i  = '0;
    src_valid_i = 1'b0;
    dst_ready_i = 1'b0;

    // Reset: idle outputs during and after
    for (int i = 0; i < 3; i++) begin
      tick();
      check_value("rst_ready", src_ready_o, 1);
      check_value("rst_valid", dst_valid_o, 0);
      check_value("rst_data", dst_data_o, 0);
    end
    rst_i = 1'b0;
    tick();
    check_value("post_rst_ready", src_ready_o, 1);
    check_value("post_rst_valid", dst_valid_o, 0);

    // Single transfer with destination backpressure
    src_data_i  = 32'h0000_0001;
    src_valid_i = 1'b1;
    tick();
    src_valid_i = 1'b0;
    src_data_i  = '0;
    check_value("accept_drops_ready", src_ready_o, 0);
    for (int i = 0; i < S; i++) begin
      check_value("single_not_yet_valid", dst_valid_o, 0);
      tick();
    end
    check_value("single_valid_at_k+S", dst_valid_o, 1);
    check_value("single_data", dst_data_o, 32'h0000_0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_value("single_held_valid", dst_valid_o, 1);
      check_value("single_held_data", dst_data_o, 32'h0000_0001);
    end
    dst_ready_i = 1'b1;
    check_value("single_ready_still_low", src_ready_o, 0);
    tick();
    dst_ready_i = 1'b0;
    check_value("single_valid_drops", dst_valid_o, 0);
    for (int i = 0; i < S; i++) begin
      check_value("single_ack_not_back", src_ready_o, 0);
      tick();
    end
    check_value("single_ready_at_m+S", src_ready_o, 1);

    // Back-to-back with dst_ready held high
    words[0] = 32'h1234_5678;
    words[1] = 32'h123D_EFEF;
    idx = 0; rx = 0; first_rx = -1;
    acc[0] = -1; acc[1] = -1;
    dst_ready_i = 1'b1;
    for (int c = 0; c < 40 && rx < 2; c++) begin
      src_valid_i = (idx < 2);
      src_data_i  = (idx < 2) ? words[idx] : '0;
      fire_src = src_valid_i && src_ready_o;
      fire_dst = dst_valid_o && dst_ready_i;
      rx_word  = dst_data_o;
      tick();
      if (fire_src) begin
        acc[idx] = cycle;
        idx++;
      end
      if (fire_dst) begin
        if (rx == 0) first_rx = cycle;
        check_value(rx == 0 ? "b2b_word0" : "b2b_word1", rx_word, words[rx]);
        rx++;
      end
    end
    src_valid_i = 1'b0;
    check_value("b2b_accepted", idx, 2);
    check_value("b2b_delivered", rx, 2);
    check_value("b2b_period", acc[1] - acc[0], 2 * S + 2);
    check_value("b2b_first_latency", first_rx - acc[0], S + 1);
    valid_seen = 0;
    for (int i = 0; i < 2 * S + 2; i++) begin
      if (dst_valid_o) valid_seen++;
      tick();
    end
    check_value("b2b_no_extra_delivery", valid_seen, 0);
    check_value("b2b_idle_ready", src_ready_o, 1);
    dst_ready_i = 1'b0;

    // Source holds valid/data through backpressure
    src_data_i  = 32'h1234_5678;
    src_valid_i = 1'b1;
    accepts = 0;
    for (int i = 0; i < 14; i++) begin
      if (src_valid_i && src_ready_o) accepts++;
      tick();
    end
    check_value("hold_single_accept", accepts, 1);
    check_value("hold_valid", dst_valid_o, 1);
    check_value("hold_data", dst_data_o, 32'h1234_5678);
    check_value("hold_ready_low", src_ready_o, 0);
    src_valid_i = 1'b0;
    src_data_i  = '0;
    dst_ready_i = 1'b1;
    tick();
    dst_ready_i = 1'b0;
    check_value("hold_drain_valid", dst_valid_o, 0);
    for (int i = 0; i < S; i++) tick();
    check_value("hold_drain_ready", src_ready_o, 1);

    // Reset right after accepting a word
    src_data_i  = 32'hABCD_EFEF;
    src_valid_i = 1'b1;
    dst_ready_i = 1'b1;
    tick();
    src_valid_i = 1'b0;
    check_value("midrst_accepted", src_ready_o, 0);
    rst_i = 1'b1;
    #1;
    check_value("midrst_ready_immediate", src_ready_o, 1);
    check_value("midrst_data_cleared", dst_data_o, 0);
    tick();
    tick();
    rst_i = 1'b0;
    valid_seen = 0;
    for (int i = 0; i < 2 * S + 4; i++) begin
      if (dst_valid_o) valid_seen++;
      tick();
    end
    check_value("midrst_never_valid", valid_seen, 0);
    check_value("midrst_idle_ready", src_ready_o, 1);
    dst_ready_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
